io_port: RTL and testbench
==========================

Name: io_port

Overview:
Parametrised memory-mapped I/O block for the tiny16 system bus. It replaces the fixed 8-bit display latch with the following:
- NUM_OUT output channels.
- A synchronised input port.
- Per-bit edge capture with a maskable interrupt.

It uses the same addr_en/in_en/out_en bus handshake as memory, so the controller can treat I/O as ordinary load/store space. pins_out drives the board outputs; pins_in comes from the board inputs.

Parameters:
BASE_ADDR, 16'hFF00, first bus address of the register window.
NUM_OUT, 2, number of output channel registers (1..8).
OUT_WIDTH, 8, bits per output channel (1..16).
IN_WIDTH, 8, width of pins_in (1..16).

Ports:
clk  input  1  system clock (clk_1mhz domain)
rst  input  1  synchronous, active-high reset
addr_en  input  1  latch addr on this edge
addr  input  16  bus address
in_en  input  1  write in to the selected register on this edge
in  input  16  bus write data
out_en  input  1  drive selected register onto out
out  output  16  read data; 16'h0000 when out_en low or address misses
pins_in  input  IN_WIDTH  asynchronous external inputs
pins_out  output  NUM_OUT*OUT_WIDTH  channel k at bits [k*OUT_WIDTH +: OUT_WIDTH]
irq  output  1  level interrupt request

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: latched address = 0, all channels = 0, sync flops = 0, prev sample = 0, status = 0, mask = 0. Consequently pins_out = 0, irq = 0, out = 0.
- Address latch: on a clk edge with addr_en=1, addr_q <= addr. offset = addr_q - BASE_ADDR. hit = (addr_q >= BASE_ADDR) && (offset < NUM_OUT+3).
- Register map (offset):
  - 0..NUM_OUT-1: CHANNEL[k], R/W, OUT_WIDTH bits. Writes take in[OUT_WIDTH-1:0]; reads are zero-extended.
  - NUM_OUT: INPUT, RO. Returns the synchronised pins_in, zero-extended. Writes are ignored.
  - NUM_OUT+1: STATUS, IN_WIDTH bits, write-1-to-clear.
  - NUM_OUT+2: MASK, IN_WIDTH bits, R/W.
- Write: on a clk edge with in_en=1 and hit, the register at offset is updated from in. If addr_en and in_en are both high in the same cycle, the write uses the previous addr_q; the new address applies from the next cycle.
- Read: out is combinational from addr_q and the register contents while out_en=1 and hit; otherwise 16'h0000.
  - Zero-latency read matches the memory contract; the bus mux takes out only when out_en is high.
  - A read in the same cycle as a write returns the pre-write value.
- Input path:
  - 2-flop synchroniser: s1 <= pins_in, s2 <= s1. INPUT reads s2.
  - prev <= s2 every cycle.
  - Rising edge on bit i: s2[i] & ~prev[i]. It is visible in STATUS two clocks after the edge is registered.
- Status update (per bit, each cycle): status[i] <= edge[i] | (status[i] & ~w1c[i]). w1c[i] = in[i] during a write hit to STATUS.
  - A new edge coinciding with a clear leaves the bit set.
- irq = |(status & mask), registered, so it asserts one cycle after status/mask change.
- pins_out is the direct concatenation of the channel registers. No glitch path from the bus.
- Reset mid-operation: rst dominates addr_en, in_en and edges in the same cycle. Pending status is lost.
- Out-of-window accesses: reads return 0, writes have no effect, and nothing changes in this block.

Optional Feature:
IO_BOTH_EDGES_EN
- Defined: edge[i] = s2[i] ^ prev[i], so both rising and falling transitions set status.
- Undefined: rising edges only, as above.
- The register map and timing are identical in both builds.

Test Plan:
1. Reset: hold rst 2 cycles with in_en=1, in=16'hFFFF, addr=16'hFF00 -> pins_out=0, irq=0, out=0 with out_en=1.
2. Channel write/read, default params: addr_en with addr=FF01, then in_en with in=16'h12A5 -> pins_out[15:8]=8'hA5. Read with out_en=1 -> out=16'h00A5. Channel 0 remains 0.
3. Miss and same-cycle latch: addr_en with addr=FF00. Next cycle, addr_en with addr=FE00 together with in_en, in=16'h0033 -> channel 0 = 8'h33 (old address used). A following write of 16'h0044 -> no change. A read -> out=0.
4. Edge and irq:
   - Write MASK (FF04) = 16'h0001, then raise pins_in[0] -> STATUS (FF03) reads 16'h0001 and irq=1 within 4 clocks.
   - Write FF03 = 16'h0001 -> status=0, irq drops one cycle later.
   - Lower pins_in[0] -> status stays 0 (sets to 1 with IO_BOTH_EDGES_EN).
5. Clear/edge collision: time a new rising edge on bit 1 to reach status in the same cycle as a W1C of 16'h0002 -> status[1]=1 afterwards.
6. Parameter sweep: NUM_OUT=4, OUT_WIDTH=16, IN_WIDTH=4, BASE_ADDR=16'h8000:
   - Write 16'hBEEF to 16'h8003 -> pins_out[63:48]=16'hBEEF.
   - Read 16'h8004 -> out[15:4]=0.
   - 16'h8007 is a miss (out=0).

Source files
------------

// File: rtl/io_port.sv
// Memory-mapped I/O block for the tiny16 bus: channel outputs, synchronised inputs and edge-capture interrupt.
// Build option: define IO_BOTH_EDGES_EN to capture falling as well as rising input edges.
module io_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          NUM_OUT   = 2,
    parameter int          OUT_WIDTH = 8,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         addr_en,
    input  logic [15:0]                  addr,
    input  logic                         in_en,
    input  logic [15:0]                  in,
    input  logic                         out_en,
    output logic [15:0]                  out,
    input  logic [IN_WIDTH-1:0]          pins_in,
    output logic [NUM_OUT*OUT_WIDTH-1:0] pins_out,
    output logic                         irq
);

    localparam logic [15:0] OFF_INPUT  = 16'(NUM_OUT);
    localparam logic [15:0] OFF_STATUS = 16'(NUM_OUT + 1);
    localparam logic [15:0] OFF_MASK   = 16'(NUM_OUT + 2);
    localparam logic [15:0] WIN_SIZE   = 16'(NUM_OUT + 3);

    logic [15:0]          addr_q;
    logic [15:0]          offset;
    logic                 hit;
    logic                 wr_hit;
    logic [OUT_WIDTH-1:0] chan [NUM_OUT];
    logic [IN_WIDTH-1:0]  s1, s2, prev;
    logic [IN_WIDTH-1:0]  status, mask;
    logic [IN_WIDTH-1:0]  edges;
    logic [IN_WIDTH-1:0]  w1c;
    logic                 irq_q;
    logic [15:0]          rdata;
    logic                 unused_in;

    assign offset = addr_q - BASE_ADDR;
    assign hit    = (addr_q >= BASE_ADDR) && (offset < WIN_SIZE);
    assign wr_hit = in_en && hit;

`ifdef IO_BOTH_EDGES_EN
    assign edges = s2 ^ prev;
`else
    assign edges = s2 & ~prev;
`endif

    assign w1c       = (wr_hit && offset == OFF_STATUS) ? in[IN_WIDTH-1:0] : '0;
    assign unused_in = ^in;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) chan[k] <= '0;
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            status <= '0;
            mask   <= '0;
            irq_q  <= 1'b0;
        end else begin
            // Writes decode against the address latched on an earlier edge.
            if (addr_en) addr_q <= addr;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_hit && offset == 16'(k)) chan[k] <= in[OUT_WIDTH-1:0];
            end
            if (wr_hit && offset == OFF_MASK) mask <= in[IN_WIDTH-1:0];
            s1     <= pins_in;
            s2     <= s1;
            prev   <= s2;
            // A fresh edge wins over a simultaneous clear.
            status <= edges | (status & ~w1c);
            irq_q  <= |(status & mask);
        end
    end

    always_comb begin
        rdata = '0;
        if (out_en && hit) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (offset == 16'(k)) rdata[OUT_WIDTH-1:0] = chan[k];
            end
            if (offset == OFF_INPUT)  rdata[IN_WIDTH-1:0] = s2;
            if (offset == OFF_STATUS) rdata[IN_WIDTH-1:0] = status;
            if (offset == OFF_MASK)   rdata[IN_WIDTH-1:0] = mask;
        end
    end

    assign out = rdata;
    assign irq = irq_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_pins
        assign pins_out[g*OUT_WIDTH +: OUT_WIDTH] = chan[g];
    end

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: default-parameter instance plus a swept-parameter instance on a shared bus.
module tb_io_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_en;
    logic [15:0] addr;
    logic        in_en;
    logic [15:0] in;
    logic        out_en;
    logic [15:0] out, out2;
    logic [7:0]  pins_in;
    logic [3:0]  pins_in2;
    logic [15:0] pins_out;
    logic [63:0] pins_out2;
    logic        irq, irq2;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    io_port dut (
        .clk(clk), .rst(rst), .addr_en(addr_en), .addr(addr), .in_en(in_en), .in(in),
        .out_en(out_en), .out(out), .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
    );

    io_port #(.BASE_ADDR(16'h8000), .NUM_OUT(4), .OUT_WIDTH(16), .IN_WIDTH(4)) dut_p (
        .clk(clk), .rst(rst), .addr_en(addr_en), .addr(addr), .in_en(in_en), .in(in),
        .out_en(out_en), .out(out2), .pins_in(pins_in2), .pins_out(pins_out2), .irq(irq2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic latch(input logic [15:0] a);
        addr_en = 1'b1;
        addr    = a;
        tick();
        addr_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        latch(a);
        in_en = 1'b1;
        in    = d;
        tick();
        in_en = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a write attempt held on the bus.
        rst = 1'b1; addr_en = 1'b1; addr = 16'hFF00; in_en = 1'b1; in = 16'hFFFF;
        out_en = 1'b1; pins_in = '0; pins_in2 = '0;
        tick(); tick();
        push(64'h0); chk("rst_pins_out", 64'(pins_out));
        push(64'h0); chk("rst_irq", 64'(irq));
        push(64'h0); chk("rst_out", 64'(out));
        push(64'h0); chk("rst_pins_out2", pins_out2);
        rst = 1'b0; addr_en = 1'b0; in_en = 1'b0; in = '0;
        tick();

        // Channel 1 write and readback.
        wr(16'hFF01, 16'h12A5);
        push(64'hA500); chk("ch1_pins_out", 64'(pins_out));
        out_en = 1'b1;
        #1;
        push(64'h00A5); chk("ch1_read", 64'(out));
        out_en = 1'b0;
        #1;
        push(64'h0); chk("read_out_en_low", 64'(out));
        out_en = 1'b1;

        // Same-cycle latch uses old address; subsequent miss write ignored.
        latch(16'hFF00);
        addr_en = 1'b1; addr = 16'hFE00; in_en = 1'b1; in = 16'h0033;
        tick();
        addr_en = 1'b0; in_en = 1'b0;
        push(64'hA533); chk("same_cycle_latch", 64'(pins_out));
        in_en = 1'b1; in = 16'h0044;
        tick();
        in_en = 1'b0;
        push(64'hA533); chk("miss_write", 64'(pins_out));
        push(64'h0); chk("miss_read", 64'(out));

        // Edge capture and interrupt on bit 0.
        wr(16'hFF04, 16'h0001);
        push(64'h0001); chk("mask_read", 64'(out));
        pins_in = 8'h01; addr_en = 1'b1; addr = 16'hFF03;
        tick();
        addr_en = 1'b0;
        tick(); tick();
        push(64'h0001); chk("status_rise", 64'(out));
        push(64'h0); chk("irq_before", 64'(irq));
        tick();
        push(64'h1); chk("irq_set", 64'(irq));
        in_en = 1'b1; in = 16'h0001;
        tick();
        in_en = 1'b0;
        push(64'h0); chk("status_w1c", 64'(out));
        push(64'h1); chk("irq_lag", 64'(irq));
        tick();
        push(64'h0); chk("irq_drop", 64'(irq));

        pins_in = 8'h00;
        tick(); tick(); tick();
`ifdef IO_BOTH_EDGES_EN
        push(64'h0001);
`else
        push(64'h0000);
`endif
        chk("status_fall", 64'(out));
        in_en = 1'b1; in = 16'h0001;
        tick();
        in_en = 1'b0;
        tick();
        push(64'h0); chk("status_recleared", 64'(out));

        // Rising edge on bit 1 lands in the same cycle as its clear.
        pins_in = 8'h02;
        tick(); tick();
        in_en = 1'b1; in = 16'h0002;
        tick();
        in_en = 1'b0;
        push(64'h0002); chk("collision_status", 64'(out));
        in_en = 1'b1; in = 16'h0002;
        tick();
        in_en = 1'b0;
        push(64'h0); chk("collision_clear", 64'(out));
        tick();
        push(64'h0); chk("irq_masked", 64'(irq));
        wr(16'hFF02, 16'h00FF);
        push(64'h0002); chk("input_read_ro", 64'(out));

        // Swept-parameter instance.
        pins_in2 = 4'h5;
        wr(16'h8003, 16'hBEEF);
        push({16'hBEEF, 48'h0}); chk("sweep_ch3", pins_out2);
        push(64'hA533); chk("sweep_no_cross", 64'(pins_out));
        latch(16'h8004);
        push(64'h0005); chk("sweep_input", 64'(out2));
        push(64'h0); chk("sweep_default_miss", 64'(out));
        latch(16'h8007);
        push(64'h0); chk("sweep_miss", 64'(out2));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected values never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
